mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Shares one external shift_add-style multiplier (start/done, 4-bit A/B, 8-bit P) among NREQ requesters.
//  Round-robin arbitration picks one requester, latches its operands and pulses mul_start.
//  It then waits for mul_done, captures the product and returns it to the winner over a valid/ready response.
//  Sits between the client blocks and the single multiplier instance in the datapath.
// PARAMETERS
//  NREQ         4   number of requesters (2..8)
//  W            4   operand width; product width 2*W
//  TIMEOUT_CYC  15  WAIT-state watchdog limit in cycles; used only with MUL_ARB_TIMEOUT_EN
// PORTS
//  clk        in   1          clock; all state updates on the rising edge
//  rst_n      in   1          asynchronous reset, active-low
//  req_valid  in   NREQ       per-requester request valid
//  req_ready  out  NREQ       per-requester accept; at most one bit high
//  req_a      in   NREQ*W     operand A, requester i at [i*W +: W]
//  req_b      in   NREQ*W     operand B, requester i at [i*W +: W]
//  rsp_valid  out  NREQ       one-hot response valid to the granted requester
//  rsp_ready  in   NREQ       per-requester response ready
//  rsp_p      out  2*W        product; shared by all requesters, qualified by rsp_valid
//  rsp_err    out  1          watchdog error flag, qualified by rsp_valid
//  grant_id   out  clog2(NREQ) index of the current or last granted requester
//  busy       out  1          high in any state other than IDLE
//  mul_start  out  1          one-cycle start pulse to the multiplier
//  mul_a      out  W          registered operand A to the multiplier
//  mul_b      out  W          registered operand B to the multiplier
//  mul_p      in   2*W        multiplier product
//  mul_done   in   1          multiplier done; level signal, stays high until the next start
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State goes to IDLE.
//   - All outputs are 0: req_ready, rsp_valid, rsp_p, rsp_err, grant_id, busy, mul_start, mul_a, mul_b.
//   - RR pointer last = NREQ-1, so req 0 has highest priority first.
//   - Reset mid-operation abandons the transaction; no response is issued.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE
//   - Winner = first set req_valid bit searching last+1, last+2, ... (mod NREQ).
//   - req_ready[winner] = 1 combinationally; it is the only req_ready bit ever high.
//   - Accepting edge: mul_a/mul_b <= winner's operands, grant_id <= winner, last <= winner, go to ISSUE.
//   - No req_valid set: stay in IDLE.
//   - A requester may drop req_valid before it is accepted; no grant results.
//  ISSUE: mul_start = 1 for exactly this cycle; go to WAIT. mul_done is ignored here (stale).
//  WAIT
//   - On the first edge with mul_done=1: rsp_p <= mul_p, rsp_err <= 0, go to RESP.
//   - mul_a/mul_b are held stable through WAIT.
//  RESP
//   - rsp_valid[grant_id] = 1; rsp_p and rsp_err held stable.
//   - Leave to IDLE on the edge where rsp_ready[grant_id] = 1.
//   - rsp_ready on other bits is ignored. rsp_ready high before RESP is legal and gives 1-cycle RESP.
//  Arbitration timing
//   - No new grant in the RESP->IDLE cycle; next grant is at the earliest on the following edge.
//   - Back-to-back service: a continuously requesting client is re-granted only after all others have had a turn.
//  Latency (W=4 multiplier): rsp_valid rises on the 7th edge after the accepting edge.
//   - Edge 1: start is sampled. Edges 2-5: shift steps. Edge 6: done set. Edge 7: captured.
//  Arithmetic: no truncation; rsp_p = mul_p (2*W bits). The controller performs no arithmetic.
//  mul_done high while in IDLE or ISSUE never causes a state change.
// CONFIGURATION
//  MUL_ARB_TIMEOUT_EN defined
//   - A WAIT counter is cleared on entry to WAIT.
//   - If it reaches TIMEOUT_CYC without mul_done: go to RESP with rsp_p = 0, rsp_err = 1.
//   - The next ISSUE restarts the multiplier normally.
//  MUL_ARB_TIMEOUT_EN undefined
//   - No counter; WAIT waits indefinitely.
//   - rsp_err is a constant 0.
// TESTING
//  1. Single req0, A=3, B=5, rsp_ready=1 -> rsp_valid[0] on 7th edge after accept, rsp_p=15, rsp_err=0.
//  2. req0..3 all valid, held, continuously -> grants in order 0,1,2,3,0; only one req_ready bit high at any time.
//  3. req2 A=15, B=15, rsp_ready[2]=0 for 5 cycles -> rsp_valid[2] and rsp_p=225 held 5 cycles; no new grant.
//  4. rst_n=0 pulse in WAIT of A=7, B=9 -> all outputs 0 immediately, no response; next req1 A=2, B=6 -> rsp_p=12.
//  5. mul_done forced high in IDLE, then request A=4, B=4 -> no early capture; rsp_p=16 at the normal latency.
//  6. MUL_ARB_TIMEOUT_EN, mul_done tied 0 -> RESP after 15 WAIT cycles with rsp_p=0, rsp_err=1.

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if
//   Requester-side handshake bundle for mul_share_arbiter.
//   master : client side (drives requests and response ready)
//   slave  : arbiter side (drives request accept and response)
//   Signals:
//     req_valid/req_ready  per-requester request handshake (NREQ bits)
//     req_a/req_b          packed operands, requester i at [i*W +: W]
//     rsp_valid/rsp_ready  per-requester response handshake (NREQ bits)
//     rsp_p                shared product (2*W bits), qualified by rsp_valid
//     rsp_err              watchdog error flag, qualified by rsp_valid
interface mul_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [2*W-1:0]    rsp_p;
  logic              rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_err
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one start/done multiplier among NREQ requesters. A round-robin
//   pick in IDLE latches the winner's operands, ISSUE pulses mul_start,
//   WAIT captures mul_p on mul_done, RESP returns the product to the winner.
//   Optional feature macro: MUL_ARB_TIMEOUT_EN (WAIT watchdog; on expiry the
//   response carries rsp_p=0, rsp_err=1). Without it rsp_err is constant 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rif          requester handshake bundle (slave modport)
//   grant_id     index of current/last granted requester
//   busy         high whenever not IDLE
//   mul_start    one-cycle start pulse to the multiplier
//   mul_a/mul_b  registered operands to the multiplier
//   mul_p        multiplier product
//   mul_done     multiplier done level
module mul_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int W           = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mul_share_arbiter_if.slave      rif,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    mul_start,
  output logic [W-1:0]            mul_a,
  output logic [W-1:0]            mul_b,
  input  logic [2*W-1:0]          mul_p,
  input  logic                    mul_done
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last) + k) % NREQ);
      if (!win_found && rif.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    rif.req_ready = '0;
    if (state == IDLE && win_found) rif.req_ready[win_idx] = 1'b1;
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wcnt;
  logic          err_q;
  assign rif.rsp_err = err_q;
`else
  assign rif.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= IDW'(NREQ - 1);
      grant_id      <= '0;
      busy          <= 1'b0;
      mul_start     <= 1'b0;
      mul_a         <= '0;
      mul_b         <= '0;
      rif.rsp_valid <= '0;
      rif.rsp_p     <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      wcnt          <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            mul_a     <= rif.req_a[int'(win_idx)*W +: W];
            mul_b     <= rif.req_b[int'(win_idx)*W +: W];
            grant_id  <= win_idx;
            last      <= win_idx;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        // mul_done may still be high from the previous product here; ignore it.
        ISSUE: begin
          mul_start <= 1'b0;
          state     <= WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
          wcnt      <= '0;
`endif
        end
        WAIT: begin
          if (mul_done) begin
            rif.rsp_p     <= mul_p;
            rif.rsp_valid <= NREQ'(1) << grant_id;
            state         <= RESP;
`ifdef MUL_ARB_TIMEOUT_EN
            err_q         <= 1'b0;
          end else if (wcnt == TW'(TIMEOUT_CYC - 1)) begin
            // TIMEOUT_CYC full WAIT cycles without done.
            rif.rsp_p     <= '0;
            rif.rsp_valid <= NREQ'(1) << grant_id;
            err_q         <= 1'b1;
            state         <= RESP;
          end else begin
            wcnt          <= wcnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rif.rsp_ready[grant_id]) begin
            rif.rsp_valid <= '0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Directed bench for mul_share_arbiter with a behavioural shift/add-timed
//   multiplier (start sampled, 4 step edges, done on the 6th edge).
module tb_mul_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.NREQ(NREQ), .W(W)) rif();

  logic [1:0]   grant_id;
  logic         busy;
  logic         mul_start;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [7:0]   mul_p;
  logic         mul_done;

  mul_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst_n(rst_n), .rif(rif), .grant_id(grant_id), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_done(mul_done)
  );

  // Multiplier model; not reset by rst_n so a stale done can survive.
  logic [3:0] m_a    = '0;
  logic [3:0] m_b    = '0;
  logic [2:0] m_cnt  = '0;
  logic       m_run  = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_p    = '0;
  logic       force_hi = 1'b0;
  logic       tie_lo   = 1'b0;

  always @(posedge clk) begin
    if (mul_start) begin
      m_a <= mul_a; m_b <= mul_b; m_cnt <= 3'(W); m_run <= 1'b1; m_done <= 1'b0;
    end else if (m_run) begin
      if (m_cnt != 3'd0) m_cnt <= m_cnt - 3'd1;
      else begin
        m_run <= 1'b0; m_done <= 1'b1; m_p <= 8'(m_a) * 8'(m_b);
      end
    end
  end
  assign mul_done = force_hi | (m_done & ~tie_lo);
  assign mul_p    = m_p;

  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;

  always @(negedge clk)
    if (rst_n && ($countones(rif.req_ready) > 1 || (busy && rif.req_ready != '0))) viol++;

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  // Ticks until rsp_valid rises; n = edges taken (40 if it never does).
  task automatic wait_rsp(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (rif.rsp_valid != '0) break;
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    rif.req_a[i*W +: W] = a;
    rif.req_b[i*W +: W] = b;
  endtask

  function automatic logic [31:0] outs();
    return 32'({rif.req_ready, rif.rsp_valid, rif.rsp_p, rif.rsp_err, grant_id,
                busy, mul_start, mul_a, mul_b});
  endfunction

  int n;
  int seq[5]   = '{0, 1, 2, 3, 0};
  int exp_p[4] = '{2, 6, 12, 20};
  logic [31:0] acc;

  initial begin
    rif.req_valid = '0; rif.req_a = '0; rif.req_b = '0; rif.rsp_ready = '0;
    tick(); tick();
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;

    // 1: single request 3*5
    rif.rsp_ready = '1;
    set_op(0, 4'd3, 4'd5);
    rif.req_valid = 4'b0001; #1;
    chk("t1_req_ready", 32'(rif.req_ready), 32'b0001);
    tick(); rif.req_valid = '0;
    chk("t1_issue", 32'({mul_start, busy, grant_id, mul_a, mul_b}), 32'({2'b11, 2'd0, 4'd3, 4'd5}));
    wait_rsp(n);
    chk("t1_latency", 32'(n), 7);
    chk("t1_rsp_valid", 32'(rif.rsp_valid), 32'b0001);
    chk("t1_rsp_p", 32'(rif.rsp_p), 15);
    chk("t1_rsp_err", 32'(rif.rsp_err), 0);
    tick();
    chk("t1_idle", 32'({busy, rif.rsp_valid}), 0);

    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // 2: all four requesting continuously
    for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'(i + 2));
    rif.req_valid = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk($sformatf("t2_ready_%0d", s), 32'(rif.req_ready), 32'(1) << seq[s]);
      tick();
      chk($sformatf("t2_grant_%0d", s), 32'(grant_id), 32'(seq[s]));
      wait_rsp(n);
      chk($sformatf("t2_lat_%0d", s), 32'(n), 7);
      chk($sformatf("t2_valid_%0d", s), 32'(rif.rsp_valid), 32'(1) << seq[s]);
      chk($sformatf("t2_p_%0d", s), 32'(rif.rsp_p), 32'(exp_p[seq[s]]));
      tick();
    end
    rif.req_valid = '0;

    // 3: 15*15 with response back-pressure; req0 also waiting
    set_op(2, 4'd15, 4'd15);
    rif.rsp_ready = 4'b1011;
    rif.req_valid = 4'b0101; #1;
    chk("t3_req_ready", 32'(rif.req_ready), 32'b0100);
    tick();
    wait_rsp(n);
    chk("t3_latency", 32'(n), 7);
    chk("t3_rsp", 32'({rif.rsp_valid, rif.rsp_p}), 32'({4'b0100, 8'd225}));
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t3_hold_%0d", c), 32'({rif.rsp_valid, rif.rsp_p, rif.req_ready, grant_id}),
          32'({4'b0100, 8'd225, 4'b0000, 2'd2}));
    end
    rif.rsp_ready = 4'b1111;
    tick();
    chk("t3_released", 32'({busy, rif.rsp_valid}), 0);
    chk("t3_next_ready", 32'(rif.req_ready), 32'b0001);
    rif.req_valid = '0; #1;
    chk("t3_drop_ready", 32'(rif.req_ready), 0);
    tick();
    chk("t3_drop_idle", 32'(busy), 0);

    // 5: stale done high in IDLE/ISSUE, request 4*4 on req3
    force_hi = 1'b1;
    tick(); tick();
    chk("t5_idle_done", 32'({busy, rif.rsp_valid}), 0);
    set_op(3, 4'd4, 4'd4);
    rif.req_valid = 4'b1000; #1;
    chk("t5_req_ready", 32'(rif.req_ready), 32'b1000);
    tick(); rif.req_valid = '0;
    chk("t5_issue", 32'({mul_start, grant_id}), 32'({1'b1, 2'd3}));
    tick();
    chk("t5_no_early", 32'({mul_start, busy, rif.rsp_valid}), 32'({1'b0, 1'b1, 4'b0000}));
    force_hi = 1'b0;
    wait_rsp(n);
    chk("t5_latency", 32'(n), 6);
    chk("t5_rsp", 32'({rif.rsp_valid, rif.rsp_p}), 32'({4'b1000, 8'd16}));
    tick();

    // 4: reset during WAIT of 7*9, then 2*6 on req1
    set_op(1, 4'd7, 4'd9);
    rif.req_valid = 4'b0010; #1;
    tick(); rif.req_valid = '0;
    tick(); tick(); tick();
    chk("t4_in_wait", 32'({busy, mul_a, mul_b}), 32'({1'b1, 4'd7, 4'd9}));
    rst_n = 1'b0; #1;
    chk("t4_async_rst", outs(), 0);
    tick(); rst_n = 1'b1;
    acc = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      acc = acc | 32'({rif.rsp_valid, busy});
    end
    chk("t4_no_rsp", acc, 0);
    set_op(1, 4'd2, 4'd6);
    rif.req_valid = 4'b0010; #1;
    chk("t4_req_ready", 32'(rif.req_ready), 32'b0010);
    tick(); rif.req_valid = '0;
    wait_rsp(n);
    chk("t4_latency", 32'(n), 7);
    chk("t4_rsp", 32'({rif.rsp_valid, rif.rsp_p, rif.rsp_err}), 32'({4'b0010, 8'd12, 1'b0}));
    tick();

`ifdef MUL_ARB_TIMEOUT_EN
    // 6: watchdog with done tied low, then a normal 3*3
    tie_lo = 1'b1;
    set_op(0, 4'd1, 4'd1);
    rif.req_valid = 4'b0001; #1;
    tick(); rif.req_valid = '0;
    tick();
    wait_rsp(n);
    chk("t6_wait_cycles", 32'(n), 15);
    chk("t6_rsp", 32'({rif.rsp_valid, rif.rsp_p, rif.rsp_err}), 32'({4'b0001, 8'd0, 1'b1}));
    tick();
    tie_lo = 1'b0;
    set_op(0, 4'd3, 4'd3);
    rif.req_valid = 4'b0001; #1;
    tick(); rif.req_valid = '0;
    wait_rsp(n);
    chk("t6_recover_lat", 32'(n), 7);
    chk("t6_recover_rsp", 32'({rif.rsp_valid, rif.rsp_p, rif.rsp_err}), 32'({4'b0001, 8'd9, 1'b0}));
    tick();
`endif

    chk("req_ready_onehot", 32'(viol), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
